lfsr_decrypt_engine: RTL

Hardware decrypt/de-pad engine for the encrypted-message datapath. It reads a parity-protected, LFSR-encrypted byte stream from data memory and recovers the LFSR seed from the known all-space preamble. It then searches a configurable table of tap patterns for the one in use, decrypts the stream, strips leading spaces, and writes the result with per-byte parity-error flags. It replaces the software decrypt program and generalises it in LFSR width, message length, pattern count and preamble length.

---
 rtl/lfsr_decrypt_engine.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/lfsr_decrypt_engine.sv
// lfsr_decrypt_engine
// Recovers the LFSR seed from the all-space preamble, searches a table of
// candidate tap patterns for the one in use, decrypts the message, strips
// the leading pad bytes and writes the result to destination memory,
// zero-filling the remainder.
// Optional feature macro: LFSR_PARITY_CHECK_EN (per-byte even-parity error
// flags in bit DW-1 of each output byte, counted in err_cnt).
module lfsr_decrypt_engine #(
    parameter int DW       = 8,
    parameter int MSG_LEN  = 64,
    parameter int NUM_PTRN = 9,
    parameter int PRE_MIN  = 10,
    parameter int AW       = 8,
    parameter int SRC_BASE = 64,
    parameter int DST_BASE = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             ack,
    input  logic [NUM_PTRN*(DW-1)-1:0]       ptrn_tbl,
    output logic [AW-1:0]                    rd_addr,
    input  logic [DW-1:0]                    rd_data,
    output logic                             wr_en,
    output logic [AW-1:0]                    wr_addr,
    output logic [DW-1:0]                    wr_data,
    output logic [$clog2(NUM_PTRN)-1:0]      ptrn_idx,
    output logic                             no_match,
    output logic [$clog2(MSG_LEN+1)-1:0]     lead_cnt,
    output logic [$clog2(MSG_LEN+1)-1:0]     err_cnt
);

    localparam int LW = DW - 1;
    localparam int PW = $clog2(NUM_PTRN);
    localparam int CW = $clog2(MSG_LEN + 1);

`ifdef LFSR_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, SEED, SEARCH, DECRYPT, FILL, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            start_q;
    logic            dvld;       // rd_data holds the byte requested last cycle
    logic            lead;       // still inside the leading pad region
    logic [LW-1:0]   seed;
    logic [LW-1:0]   lfsr;
    logic [PW-1:0]   p;          // candidate index, then winning pattern
    logic [CW-1:0]   k;          // index of the byte currently on rd_data
    logic [CW-1:0]   wcnt;       // destination writes made so far
    logic [LW-1:0]   taps [NUM_PTRN];

    logic [LW-1:0]   cur;
    logic [LW-1:0]   plain;
    logic            perr;
    logic            match;
    logic            k_last;
    logic            i_last;
    logic            p_last;
    logic            fill_done;
    logic            launch;

    function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] s,
                                                input logic [LW-1:0] t);
        return {s[LW-2:0], ^(s & t)};
    endfunction

    for (genvar g = 0; g < NUM_PTRN; g++) begin : g_taps
        assign taps[g] = ptrn_tbl[g*LW +: LW];
    end

    assign cur       = rd_data[LW-1:0];
    assign plain     = cur ^ lfsr;
    assign perr      = PAR_EN & (^rd_data);
    assign match     = (cur == lfsr);
    assign k_last    = (k == CW'(PRE_MIN - 1));
    assign i_last    = (k == CW'(MSG_LEN - 1));
    assign p_last    = (p == PW'(NUM_PTRN - 1));
    assign fill_done = (wcnt == CW'(MSG_LEN));
    assign launch    = start_q & ~start;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = SEED;
            SEED:    if (dvld) state_nxt = (cur == '0) ? DONE : SEARCH;
            SEARCH:  if (dvld) begin
                         if (match && k_last)   state_nxt = DECRYPT;
                         else if (!match && p_last) state_nxt = DONE;
                     end
            DECRYPT: if (dvld && i_last) state_nxt = FILL;
            FILL:    if (fill_done) state_nxt = DONE;
            DONE:    if (start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Completion flag straight from the state
    always_comb begin
        ack = (state == DONE);
    end

    // Read pipeline, LFSR tracking, destination writes and result counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q  <= 1'b0;
            dvld     <= 1'b0;
            lead     <= 1'b0;
            seed     <= '0;
            lfsr     <= '0;
            p        <= '0;
            k        <= '0;
            wcnt     <= '0;
            rd_addr  <= AW'(SRC_BASE);
            wr_en    <= 1'b0;
            wr_addr  <= AW'(DST_BASE);
            wr_data  <= '0;
            ptrn_idx <= '0;
            no_match <= 1'b0;
            lead_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            start_q <= start;
            wr_en   <= 1'b0;
            case (state)
                IDLE: begin
                    rd_addr <= AW'(SRC_BASE);
                    dvld    <= 1'b0;
                    if (launch) begin
                        ptrn_idx <= '0;
                        no_match <= 1'b0;
                        lead_cnt <= '0;
                        err_cnt  <= '0;
                        wcnt     <= '0;
                        wr_addr  <= AW'(DST_BASE);
                        wr_data  <= '0;
                    end
                end
                SEED: begin
                    rd_addr <= rd_addr + 1'b1;
                    dvld    <= 1'b1;
                    if (dvld) begin
                        seed <= cur;
                        p    <= '0;
                        lfsr <= lfsr_step(cur, taps[0]);
                        k    <= CW'(1);
                        if (cur == '0) begin
                            no_match <= 1'b1;
                            dvld     <= 1'b0;
                            rd_addr  <= AW'(SRC_BASE);
                        end
                    end
                end
                SEARCH: begin
                    rd_addr <= rd_addr + 1'b1;
                    dvld    <= 1'b1;
                    if (dvld) begin
                        if (match) begin
                            if (k_last) begin
                                // Winner: rewind to src[0] and decrypt from the seed
                                ptrn_idx <= p;
                                lfsr     <= seed;
                                k        <= '0;
                                lead     <= 1'b1;
                                rd_addr  <= AW'(SRC_BASE);
                                dvld     <= 1'b0;
                            end else begin
                                lfsr <= lfsr_step(lfsr, taps[p]);
                                k    <= k + 1'b1;
                            end
                        end else if (p_last) begin
                            no_match <= 1'b1;
                            dvld     <= 1'b0;
                            rd_addr  <= AW'(SRC_BASE);
                        end else begin
                            // Drop the in-flight read; one bubble before src[1] returns
                            p       <= p + 1'b1;
                            lfsr    <= lfsr_step(seed, taps[p + 1'b1]);
                            k       <= CW'(1);
                            rd_addr <= AW'(SRC_BASE + 1);
                            dvld    <= 1'b0;
                        end
                    end
                end
                DECRYPT: begin
                    rd_addr <= rd_addr + 1'b1;
                    dvld    <= 1'b1;
                    if (dvld) begin
                        lfsr <= lfsr_step(lfsr, taps[p]);
                        k    <= k + 1'b1;
                        if (lead && plain == '0 && !perr) begin
                            lead_cnt <= lead_cnt + 1'b1;
                        end else begin
                            lead    <= 1'b0;
                            wr_en   <= 1'b1;
                            wr_addr <= AW'(DST_BASE) + AW'(wcnt);
                            wr_data <= {perr, plain};
                            wcnt    <= wcnt + 1'b1;
                            if (perr) err_cnt <= err_cnt + 1'b1;
                        end
                        if (i_last) begin
                            dvld    <= 1'b0;
                            rd_addr <= AW'(SRC_BASE);
                        end
                    end
                end
                FILL: begin
                    dvld <= 1'b0;
                    if (!fill_done) begin
                        wr_en   <= 1'b1;
                        wr_addr <= AW'(DST_BASE) + AW'(wcnt);
                        wr_data <= '0;
                        wcnt    <= wcnt + 1'b1;
                    end
                end
                DONE: begin
                    dvld <= 1'b0;
                end
                default: begin
                    dvld <= 1'b0;
                end
            endcase
        end
    end

endmodule
